// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Forward-select encoding, MDU FSM states and the register-match rule.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } hz_state_e;

  // Addresses are zero-extended to 32 bits so one helper
  // serves any register-address width.
  function automatic logic is_match(
    input logic [31:0] addr,
    input logic [31:0] rd,
    input logic        we
  );
    return we && (rd != '0) && (addr == rd);
  endfunction

endpackage

// File: rtl/hazard_if.sv
// Hazard-control bundle between datapath (master) and controller (slave).
// Carries stage register addresses/enables in, stall/flush/forward/counters out.
interface hazard_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);

  logic [REG_AW-1:0] rs1D;
  logic [REG_AW-1:0] rs2D;
  logic [REG_AW-1:0] rs1E;
  logic [REG_AW-1:0] rs2E;
  logic [REG_AW-1:0] rdE;
  logic [REG_AW-1:0] rdM;
  logic [REG_AW-1:0] rdW;
  logic              regwriteE;
  logic              regwriteM;
  logic              regwriteW;
  logic              result_srcE;
  logic              mdu_opE;
  logic              pc_src;
  logic              perf_clr;

  logic [1:0]        forwardAE;
  logic [1:0]        forwardBE;
  logic              stallF;
  logic              stallD;
  logic              stallE;
  logic              flushD;
  logic              flushE;
  logic              flushM;
  logic              mdu_busy;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_events;

  modport master (
    output rs1D, rs2D, rs1E, rs2E,
    output rdE, rdM, rdW,
    output regwriteE, regwriteM, regwriteW,
    output result_srcE, mdu_opE,
    output pc_src, perf_clr,
    input  forwardAE, forwardBE,
    input  stallF, stallD, stallE,
    input  flushD, flushE, flushM,
    input  mdu_busy,
    input  stall_cycles, flush_events
  );

  modport slave (
    input  rs1D, rs2D, rs1E, rs2E,
    input  rdE, rdM, rdW,
    input  regwriteE, regwriteM, regwriteW,
    input  result_srcE, mdu_opE,
    input  pc_src, perf_clr,
    output forwardAE, forwardBE,
    output stallF, stallD, stallE,
    output flushD, flushE, flushM,
    output mdu_busy,
    output stall_cycles, flush_events
  );

endinterface

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter with synchronous clear.
// Ports: clk, rst_n, i_inc (count), i_clr (clear, wins), o_cnt.
module hazard_perf_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use/RAW stalls, MDU hold.
// Ports: clk, rst_n, hz (hazard_if.slave) with controls and perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int FWD_EN  = 1,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic    clk,
  input  logic    rst_n,
  hazard_if.slave hz
);

  localparam int CW = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD =
    CW'((MDU_LAT > 1) ? (MDU_LAT - 2) : 0);

  hz_state_e   r_state;
  hz_state_e   w_state_nx;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;

  logic w_mdu_stall;
  logic w_busy;
  logic w_d1E, w_d2E, w_d1M, w_d2M;
  logic w_ld_use;
  logic w_raw;
  logic w_hzd;

  fwd_sel_e w_fwdA;
  fwd_sel_e w_fwdB;

  logic w_stallF, w_stallD, w_stallE;
  logic w_flushD, w_flushE, w_flushM;
  logic w_flush_ev;

  logic [CNT_W-1:0] w_stall_cnt;
  logic [CNT_W-1:0] w_flush_cnt;

  function automatic logic [31:0] ext(
    input logic [REG_AW-1:0] a
  );
    return 32'(a);
  endfunction

  assign w_d1E = is_match(ext(hz.rs1D), ext(hz.rdE),
                          hz.regwriteE);
  assign w_d2E = is_match(ext(hz.rs2D), ext(hz.rdE),
                          hz.regwriteE);
  assign w_d1M = is_match(ext(hz.rs1D), ext(hz.rdM),
                          hz.regwriteM);
  assign w_d2M = is_match(ext(hz.rs2D), ext(hz.rdM),
                          hz.regwriteM);

  assign w_ld_use = hz.result_srcE & (w_d1E | w_d2E);
  // WB needs no stall: the register file writes first half-cycle.
  assign w_raw = (FWD_EN == 0) &
                 (w_d1E | w_d2E | w_d1M | w_d2M);
  assign w_hzd = w_ld_use | w_raw;

  always_comb begin
    w_fwdA = FWD_RF;
    w_fwdB = FWD_RF;
    if (FWD_EN != 0) begin
      if (is_match(ext(hz.rs1E), ext(hz.rdM), hz.regwriteM))
        w_fwdA = FWD_MEM;
      else if (is_match(ext(hz.rs1E), ext(hz.rdW),
                        hz.regwriteW))
        w_fwdA = FWD_WB;
      if (is_match(ext(hz.rs2E), ext(hz.rdM), hz.regwriteM))
        w_fwdB = FWD_MEM;
      else if (is_match(ext(hz.rs2E), ext(hz.rdW),
                        hz.regwriteW))
        w_fwdB = FWD_WB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // The entry cycle stalls from IDLE; the final BUSY cycle
  // (counter at 0) releases the pipeline so the op leaves EX.
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_mdu_stall = 1'b0;
    w_busy      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (hz.mdu_opE && (MDU_LAT > 1)) begin
          w_state_nx  = BUSY;
          w_cnt_nx    = CNT_LOAD;
          w_mdu_stall = 1'b1;
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          w_state_nx = IDLE;
        end else begin
          w_cnt_nx    = r_cnt - 1'b1;
          w_mdu_stall = 1'b1;
          w_busy      = 1'b1;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  always_comb begin
    w_stallF = 1'b0;
    w_stallD = 1'b0;
    w_stallE = 1'b0;
    w_flushD = 1'b0;
    w_flushE = 1'b0;
    w_flushM = 1'b0;
    unique case (1'b1)
      w_mdu_stall: begin
        w_stallF = 1'b1;
        w_stallD = 1'b1;
        w_stallE = 1'b1;
        w_flushM = 1'b1;
      end
      (!w_mdu_stall && hz.pc_src): begin
        w_flushD = 1'b1;
        w_flushE = 1'b1;
      end
      (!w_mdu_stall && !hz.pc_src && w_hzd): begin
        w_stallF = 1'b1;
        w_stallD = 1'b1;
        w_flushE = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_flush_ev = w_flushD | w_flushE;

  hazard_perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_stallF),
    .i_clr (hz.perf_clr),
    .o_cnt (w_stall_cnt)
  );

  hazard_perf_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_flush_ev),
    .i_clr (hz.perf_clr),
    .o_cnt (w_flush_cnt)
  );

  assign hz.forwardAE    = w_fwdA;
  assign hz.forwardBE    = w_fwdB;
  assign hz.stallF       = w_stallF;
  assign hz.stallD       = w_stallD;
  assign hz.stallE       = w_stallE;
  assign hz.flushD       = w_flushD;
  assign hz.flushE       = w_flushE;
  assign hz.flushM       = w_flushM;
  assign hz.mdu_busy     = w_busy;
  assign hz.stall_cycles = w_stall_cnt;
  assign hz.flush_events = w_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: forwarding build (MDU_LAT=4, CNT_W=2) and
// stall-only build (MDU_LAT=1) driven with identical stimulus.
module tb_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic weE, weM, weW, ld, mdu, pc, clr;
  } in_t;

  typedef struct packed {
    logic [1:0] fA, fB;
    logic stF, stD, stE, flD, flE, flM, busy;
  } out_t;

  typedef struct {
    in_t  in;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  in_t  cur;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hazard_if #(.REG_AW(5), .CNT_W(2))  ifA ();
  hazard_if #(.REG_AW(5), .CNT_W(16)) ifB ();

  hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .MDU_LAT(4),
                .CNT_W(2)) uA (
    .clk(clk), .rst_n(rst_n), .hz(ifA));
  hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .MDU_LAT(1),
                .CNT_W(16)) uB (
    .clk(clk), .rst_n(rst_n), .hz(ifB));

  assign ifA.rs1D = cur.rs1D;  assign ifB.rs1D = cur.rs1D;
  assign ifA.rs2D = cur.rs2D;  assign ifB.rs2D = cur.rs2D;
  assign ifA.rs1E = cur.rs1E;  assign ifB.rs1E = cur.rs1E;
  assign ifA.rs2E = cur.rs2E;  assign ifB.rs2E = cur.rs2E;
  assign ifA.rdE  = cur.rdE;   assign ifB.rdE  = cur.rdE;
  assign ifA.rdM  = cur.rdM;   assign ifB.rdM  = cur.rdM;
  assign ifA.rdW  = cur.rdW;   assign ifB.rdW  = cur.rdW;
  assign ifA.regwriteE = cur.weE; assign ifB.regwriteE = cur.weE;
  assign ifA.regwriteM = cur.weM; assign ifB.regwriteM = cur.weM;
  assign ifA.regwriteW = cur.weW; assign ifB.regwriteW = cur.weW;
  assign ifA.result_srcE = cur.ld; assign ifB.result_srcE = cur.ld;
  assign ifA.mdu_opE  = cur.mdu; assign ifB.mdu_opE  = cur.mdu;
  assign ifA.pc_src   = cur.pc;  assign ifB.pc_src   = cur.pc;
  assign ifA.perf_clr = cur.clr; assign ifB.perf_clr = cur.clr;

  out_t actA, actB;
  assign actA = {ifA.forwardAE, ifA.forwardBE, ifA.stallF,
                 ifA.stallD, ifA.stallE, ifA.flushD,
                 ifA.flushE, ifA.flushM, ifA.mdu_busy};
  assign actB = {ifB.forwardAE, ifB.forwardBE, ifB.stallF,
                 ifB.stallD, ifB.stallE, ifB.flushD,
                 ifB.flushE, ifB.flushM, ifB.mdu_busy};

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(
    int r1d, int r2d, int r1e, int r2e,
    int rde, int rdm, int rdw,
    logic [4:0] f, logic [1:0] fa, logic [1:0] fb,
    logic [2:0] s, logic fd);
    vec_t v;
    v.in = '0;
    v.in.rs1D = 5'(r1d); v.in.rs2D = 5'(r2d);
    v.in.rs1E = 5'(r1e); v.in.rs2E = 5'(r2e);
    v.in.rdE = 5'(rde); v.in.rdM = 5'(rdm);
    v.in.rdW = 5'(rdw);
    {v.in.weE, v.in.weM, v.in.weW, v.in.ld, v.in.pc} = f;
    v.exp = '0;
    v.exp.fA = fa;
    v.exp.fB = fb;
    {v.exp.stF, v.exp.stD, v.exp.flE} = s;
    v.exp.flD = fd;
    return v;
  endfunction

  // ---------------- reference model ----------------
  function automatic bit m(logic [4:0] a, logic [4:0] rd,
                           logic we);
    return we && rd != 0 && a == rd;
  endfunction

  // occ: cycles this MDU op has already spent in EX (-1 none)
  function automatic int cur_k(in_t x, int lat, int occ);
    if (occ < 0 && x.mdu && lat > 1) return 0;
    return occ;
  endfunction

  function automatic out_t model(in_t x, bit fwd, int lat,
                                 int occ);
    out_t o;
    int k;
    bit ms, hzd;
    o = '0;
    k = cur_k(x, lat, occ);
    ms = (k >= 0) && (k < lat - 1);
    o.busy = (k >= 1) && (k < lat - 1);
    if (fwd) begin
      o.fA = m(x.rs1E, x.rdM, x.weM) ? 2'd2 :
             m(x.rs1E, x.rdW, x.weW) ? 2'd1 : 2'd0;
      o.fB = m(x.rs2E, x.rdM, x.weM) ? 2'd2 :
             m(x.rs2E, x.rdW, x.weW) ? 2'd1 : 2'd0;
    end
    hzd = x.ld && (m(x.rs1D, x.rdE, x.weE) ||
                   m(x.rs2D, x.rdE, x.weE));
    if (!fwd)
      hzd = hzd || m(x.rs1D, x.rdE, x.weE) ||
            m(x.rs2D, x.rdE, x.weE) ||
            m(x.rs1D, x.rdM, x.weM) ||
            m(x.rs2D, x.rdM, x.weM);
    if (ms) begin
      o.stF = 1; o.stD = 1; o.stE = 1; o.flM = 1;
    end else if (x.pc) begin
      o.flD = 1; o.flE = 1;
    end else if (hzd) begin
      o.stF = 1; o.stD = 1; o.flE = 1;
    end
    return o;
  endfunction

  function automatic int occ_next(in_t x, int lat, int occ);
    int k;
    k = cur_k(x, lat, occ);
    if (k < 0) return -1;
    return (k + 1 >= lat) ? -1 : k + 1;
  endfunction

  function automatic int cnt_next(int c, bit clr, bit inc,
                                  int mx);
    if (clr) return 0;
    if (inc && c < mx) return c + 1;
    return c;
  endfunction

  vec_t tbl[13];
  int   stE_exp[4]  = '{1, 1, 1, 0};
  int   busy_exp[4] = '{0, 1, 1, 0};

  initial begin
    out_t eb, eA, eB;
    int occA, occB, scA, feA, scB, feB;

    tbl[0]  = mkv(0,0,0,0,0,0,0, 5'b00000, 0,0, 3'b000, 0);
    tbl[1]  = mkv(0,0,5,0,0,5,5, 5'b01100, 2,0, 3'b000, 0);
    tbl[2]  = mkv(0,0,5,0,0,5,5, 5'b00100, 1,0, 3'b000, 0);
    tbl[3]  = mkv(0,0,0,0,0,5,5, 5'b01100, 0,0, 3'b000, 0);
    tbl[4]  = mkv(0,0,4,9,0,9,4, 5'b01100, 1,2, 3'b000, 0);
    tbl[5]  = mkv(0,0,0,0,0,0,0, 5'b01100, 0,0, 3'b000, 0);
    tbl[6]  = mkv(0,7,0,0,7,0,0, 5'b10010, 0,0, 3'b111, 0);
    tbl[7]  = mkv(0,0,0,0,0,0,0, 5'b10010, 0,0, 3'b000, 0);
    tbl[8]  = mkv(7,0,0,0,7,0,0, 5'b10011, 0,0, 3'b001, 1);
    tbl[9]  = mkv(0,0,0,0,0,0,0, 5'b00001, 0,0, 3'b001, 1);
    tbl[10] = mkv(7,0,0,0,7,0,0, 5'b10000, 0,0, 3'b000, 0);
    tbl[11] = mkv(3,0,3,0,0,3,0, 5'b01000, 2,0, 3'b000, 0);
    tbl[12] = mkv(0,6,0,0,6,0,0, 5'b00010, 0,0, 3'b000, 0);

    cur = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outA", int'(actA), 0);
    chk("rst_outB", int'(actB), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #2;
    chk("idle_outA", int'(actA), 0);
    chk("idle_scA", int'(ifA.stall_cycles), 0);
    chk("idle_feA", int'(ifA.flush_events), 0);

    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #2;
      cur = tbl[i].in;
      #2;
      chk($sformatf("tbl%0d", i), int'(actA),
          int'(tbl[i].exp));
    end

    // stall-only build: MEM and EX producers stall, WB does not
    @(posedge clk); #1;
    cur = '0;
    cur.rs1D = 3; cur.rs1E = 3; cur.rdM = 3; cur.weM = 1;
    #2;
    eb = '0; eb.stF = 1; eb.stD = 1; eb.flE = 1;
    chk("nofwd_mem", int'(actB), int'(eb));
    chk("fwd_mem_A", int'(actA.fA), 2);
    cur = '0; cur.rs1D = 3; cur.rdE = 3; cur.weE = 1;
    #2;
    chk("nofwd_ex", int'(actB), int'(eb));
    cur = '0; cur.rs2D = 3; cur.rdW = 3; cur.weW = 1;
    #2;
    chk("nofwd_wb", int'(actB), 0);

    // MDU hold with a concurrent branch
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      cur = '0;
      cur.mdu = 1;
      cur.pc = (k < 3);
      #2;
      chk($sformatf("mdu_stE%0d", k), int'(actA.stE),
          stE_exp[k]);
      chk($sformatf("mdu_flM%0d", k), int'(actA.flM),
          stE_exp[k]);
      chk($sformatf("mdu_stF%0d", k), int'(actA.stF),
          stE_exp[k]);
      chk($sformatf("mdu_busy%0d", k), int'(actA.busy),
          busy_exp[k]);
      chk($sformatf("mdu_flD%0d", k), int'(actA.flD), 0);
      chk($sformatf("lat1_stE%0d", k), int'(actB.stE), 0);
      chk($sformatf("lat1_flD%0d", k), int'(actB.flD),
          int'(cur.pc));
      @(posedge clk); #1;
    end
    cur = '0;
    #2;
    chk("mdu_done", int'(actA), 0);

    // reset in the middle of BUSY
    @(posedge clk); #1;
    cur.mdu = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_busy", int'(actA.busy), 1);
    rst_n = 1'b0;
    cur = '0;
    #1;
    chk("rstbusy_out", int'(actA), 0);
    chk("rstbusy_sc", int'(ifA.stall_cycles), 0);
    chk("rstbusy_fe", int'(ifA.flush_events), 0);
    @(negedge clk) rst_n = 1'b1;

    // saturation with the 2-bit counters, then clear
    @(posedge clk); #1;
    cur = '0;
    cur.ld = 1; cur.weE = 1; cur.rdE = 7; cur.rs2D = 7;
    repeat (4) @(posedge clk);
    #1;
    chk("sat_sc", int'(ifA.stall_cycles), 3);
    chk("sat_fe", int'(ifA.flush_events), 3);
    cur.clr = 1;
    @(posedge clk); #1;
    chk("clr_sc", int'(ifA.stall_cycles), 0);
    chk("clr_fe", int'(ifA.flush_events), 0);
    cur.clr = 0;
    cur.pc = 1;
    #1;
    eb = '0; eb.flD = 1; eb.flE = 1;
    chk("br_ld_out", int'(actA), int'(eb));
    @(posedge clk); #1;
    cur = '0;
    chk("br_ld_fe", int'(ifA.flush_events), 1);
    chk("br_ld_sc", int'(ifA.stall_cycles), 0);

    // randomized run against the model
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    occA = -1; occB = -1;
    scA = 0; feA = 0; scB = 0; feB = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 500; i++) begin
      cur.rs1D = 5'($urandom_range(0, 3));
      cur.rs2D = 5'($urandom_range(0, 3));
      cur.rs1E = 5'($urandom_range(0, 3));
      cur.rs2E = 5'($urandom_range(0, 3));
      cur.rdE  = 5'($urandom_range(0, 3));
      cur.rdM  = 5'($urandom_range(0, 3));
      cur.rdW  = 5'($urandom_range(0, 3));
      cur.weE  = 1'($urandom);
      cur.weM  = 1'($urandom);
      cur.weW  = 1'($urandom);
      cur.ld   = ($urandom_range(0, 3) == 0);
      cur.mdu  = ($urandom_range(0, 5) == 0);
      cur.pc   = ($urandom_range(0, 4) == 0);
      cur.clr  = ($urandom_range(0, 15) == 0);
      #2;
      eA = model(cur, 1'b1, 4, occA);
      eB = model(cur, 1'b0, 1, occB);
      chk($sformatf("rndA%0d", i), int'(actA), int'(eA));
      chk($sformatf("rndB%0d", i), int'(actB), int'(eB));
      chk($sformatf("rndA_sc%0d", i),
          int'(ifA.stall_cycles), scA);
      chk($sformatf("rndA_fe%0d", i),
          int'(ifA.flush_events), feA);
      chk($sformatf("rndB_sc%0d", i),
          int'(ifB.stall_cycles), scB);
      chk($sformatf("rndB_fe%0d", i),
          int'(ifB.flush_events), feB);
      @(posedge clk);
      occA = occ_next(cur, 4, occA);
      occB = occ_next(cur, 1, occB);
      scA = cnt_next(scA, cur.clr, eA.stF, 3);
      feA = cnt_next(feA, cur.clr, eA.flD | eA.flE, 3);
      scB = cnt_next(scB, cur.clr, eB.stF, 65535);
      feB = cnt_next(feB, cur.clr, eB.flD | eB.flE, 65535);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the five-stage RV32 core. It replaces the purely combinational hazard unit and adds three things: a multi-cycle EX-stage operation (MUL/DIV) that holds the pipeline for a fixed latency, a no-forwarding build mode that resolves all RAW hazards by stalling, and saturating performance counters for stall and flush events. It sits beside the datapath and drives the stall, flush and forward-select controls of the IF/ID, ID/EX and EX/MEM registers.

## Interface
- REG_AW, 5: register address width.
- FWD_EN, 1: 1 resolves RAW by forwarding from MEM/WB; 0 resolves RAW by stalling, and forward selects are tied to 00.
- MDU_LAT, 4: EX-stage cycles taken by an MDU op (≥1).
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; one clock; asynchronous, active-low
- rs1D, rs2D  in  REG_AW  source registers in ID
- rs1E, rs2E  in  REG_AW  source registers in EX
- rdE, rdM, rdW  in  REG_AW  destination registers in EX/MEM/WB
- regwriteE, regwriteM, regwriteW  in  1  destination write enable per stage
- result_srcE  in  1  EX instruction is a load
- mdu_opE  in  1  EX instruction is a MUL/DIV
- pc_src  in  1  branch/jump taken, resolved in EX
- perf_clr  in  1  synchronous clear of both counters
- forwardAE, forwardBE  out  2  00 register file, 01 WB result, 10 MEM ALU result
- stallF, stallD, stallE  out  1  hold PC, IF/ID, ID/EX
- flushD, flushE, flushM  out  1  bubble IF/ID, ID/EX, EX/MEM
- mdu_busy  out  1  FSM in BUSY
- stall_cycles, flush_events  out  CNT_W  saturating counters

## Operation
- A register match means the addresses are equal, the relevant regwrite is set, and the register is not x0.
- Forwarding (FWD_EN=1): a MEM match selects 10 and has priority over a WB match, which selects 01. Otherwise the select is 00. Each source is resolved independently.
- Load-use: result_srcE and a match of rdE against rs1D or rs2D. Response: stallF, stallD and flushE.
- No-forward RAW (FWD_EN=0): rs1D or rs2D matching rdE or rdM. Response: stallF, stallD and flushE. The register file writes in the first half-cycle, so WB needs no stall.
- MDU FSM, states IDLE and BUSY, with a down-counter of width max(1, $clog2(MDU_LAT)).
  - IDLE with mdu_opE and MDU_LAT>1: load the counter with MDU_LAT-2 and go to BUSY.
  - In BUSY, and in the entry cycle, assert stallF, stallD, stallE and flushM.
  - In BUSY with the counter at 0: go to IDLE, deasserting the stall outputs in that cycle. Otherwise decrement.
  - MDU_LAT=1: the FSM never leaves IDLE.
- Priority, highest first:
  1. MDU stall. It suppresses load-use/RAW flushE and ignores pc_src.
  2. pc_src: flushD and flushE. This overrides stallF/stallD from load-use so the redirect proceeds.
  3. Load-use/RAW.
- Counters:
  - stall_cycles increments on every cycle with stallF=1.
  - flush_events increments on every cycle with flushD or flushE set.
  - Both saturate at all-ones.
  - perf_clr has priority over increment.

## Timing
- Forward, stall and flush outputs are combinational from inputs and FSM state, valid in the same cycle.
- An MDU op occupies EX for exactly MDU_LAT cycles. The stall outputs are high for MDU_LAT-1 consecutive cycles starting in the cycle mdu_opE first rises.
- A new mdu_opE is not accepted in the cycle the FSM returns to IDLE, because the same op is still presented that cycle. The FSM enters BUSY again only after mdu_opE has been sampled low, or a different instruction occupies EX (stallE=0 on the prior cycle).
- Reset, including during BUSY: state IDLE, counter 0, stall_cycles 0, flush_events 0. With inputs idle, all outputs are 0 after reset.
- Counters update on the rising edge after the qualifying cycle.

## Structure
- Package hazard_pkg holds:
  - enum fwd_sel_e: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - enum hz_state_e: IDLE, BUSY.
  - function is_match(addr, rd, we).
- Sub-module hazard_perf_cnt: parameter W, a saturating counter with inc and clr inputs, instantiated twice.

## Test plan
- Forwarding: rs1E=5, rdM=5, regwriteM=1, rdW=5, regwriteW=1 → forwardAE=10. Drop regwriteM → 01. Set rs1E=0 → 00.
- Load-use: result_srcE=1, rdE=7, rs2D=7 → stallF, stallD and flushE for 1 cycle, then 0. rdE=0 → no stall.
- MDU: MDU_LAT=4, mdu_opE high → stallE=1 and flushM=1 for 3 cycles. mdu_busy high for 2 cycles. Concurrent pc_src=1 produces no flushD. MDU_LAT=1 → no stall.
- FWD_EN=0: regwriteM=1, rdM=3, rs1D=3 → stallF, stallD and flushE. forwardAE stays 00. Same with rdE=3.
- Branch plus load-use in the same cycle → flushD=1, flushE=1, stallF=0. flush_events +1.
- Reset mid-BUSY (cycle 2 of 4) → all outputs 0 and mdu_busy=0 immediately. With CNT_W=2, stall_cycles saturates at 3 after ≥3 stall cycles, and perf_clr returns it to 0.
